// File: rtl/c3lib_sync_filter_multi.sv
// c3lib_sync_filter_multi
// Purpose     : per-bit synchronizer with optional debounce, edge strobes and a glitch counter.
// Latency     : SYNC_STAGES edges when FILTER_DEPTH=0, SYNC_STAGES+FILTER_DEPTH edges otherwise.
// Backpressure: none; free-running, a new value is presented every clk cycle.
//
// Ports:
//   clk         destination-domain clock
//   rst_n       asynchronous active-low reset
//   data_in     WIDTH independent asynchronous inputs (quasi-static; not a bus)
//   glitch_clr  synchronous clear of glitch_cnt
//   data_out    synchronized (and debounced) value
//   rise_pls    one-cycle strobe when data_out[i] goes 0->1
//   fall_pls    one-cycle strobe when data_out[i] goes 1->0
//   filt_busy   channel i has a pending change not yet accepted by its filter
//   glitch_cnt  saturating count of cycles in which at least one change was rejected
//
// Channels are fully independent: two bits that change together at the input
// may appear at the output on different cycles.

module c3lib_sync_filter_multi #(
  parameter int               WIDTH        = 4,
  parameter int               SYNC_STAGES  = 2,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               FILTER_DEPTH = 0,
  parameter int               GCNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              glitch_clr,
  output logic [WIDTH-1:0]  data_out,
  output logic [WIDTH-1:0]  rise_pls,
  output logic [WIDTH-1:0]  fall_pls,
  output logic [WIDTH-1:0]  filt_busy,
  output logic [GCNT_W-1:0] glitch_cnt
);

  // ---------------------------------------------------------------------------
  // Parameter legality: refuse to elaborate outside the supported ranges.
  // ---------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_bad_width
    $error("c3lib_sync_filter_multi: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 5) begin : g_bad_stages
    $error("c3lib_sync_filter_multi: SYNC_STAGES must be in 2..5");
  end
  if (FILTER_DEPTH < 0 || FILTER_DEPTH > 255) begin : g_bad_depth
    $error("c3lib_sync_filter_multi: FILTER_DEPTH must be in 0..255");
  end
  if (GCNT_W < 1) begin : g_bad_gcnt
    $error("c3lib_sync_filter_multi: GCNT_W must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Synchronizer chain. Stage 0 is the only flop that sees data_in directly and
  // may go metastable; later stages give it time to resolve.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= data_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Per-channel "a pending change was abandoned this cycle" flags.
  logic [WIDTH-1:0] reject;

  // ---------------------------------------------------------------------------
  // Debounce filter (or straight bypass).
  // ---------------------------------------------------------------------------
  if (FILTER_DEPTH == 0) begin : g_bypass

    assign data_out  = sync_s;
    assign filt_busy = '0;
    assign reject    = '0;

  end else begin : g_filter

    // Counter only ever reaches FILTER_DEPTH-1 before acceptance, but it is
    // sized to hold FILTER_DEPTH so the compare constant always fits.
    localparam int               CNT_W    = $clog2(FILTER_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_DEPTH - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] out_q;

    // cnt_q[i] counts how many consecutive cycles the synchronized value has
    // disagreed with the accepted output. The new value is taken on the cycle
    // the disagreement has lasted FILTER_DEPTH cycles; any agreement before
    // that throws the pending change away.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= RESET_VAL;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_s[i] == out_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            out_q[i] <= sync_s[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end

    // Both outputs derive from registered state only: no path from data_in.
    always_comb begin
      filt_busy = '0;
      reject    = '0;
      for (int i = 0; i < WIDTH; i++) begin
        filt_busy[i] = (cnt_q[i] != '0);
        // A pending change that collapses back to the accepted value is a glitch.
        reject[i]    = filt_busy[i] && (sync_s[i] == out_q[i]);
      end
    end

    assign data_out = out_q;

  end

  // ---------------------------------------------------------------------------
  // Edge strobes. The history flop resets to RESET_VAL as well, so reset
  // release never looks like an edge.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= RESET_VAL;
    end else begin
      data_out_q <= data_out;
    end
  end

  assign rise_pls =  data_out & ~data_out_q;
  assign fall_pls = ~data_out &  data_out_q;

  // ---------------------------------------------------------------------------
  // Glitch counter: one increment per cycle no matter how many channels reject.
  // A clear that coincides with a reject keeps that reject, so it reads 1.
  // ---------------------------------------------------------------------------
  localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

  logic glitch_inc;
  assign glitch_inc = |reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= GCNT_W'(glitch_inc);
    end else if (glitch_inc && (glitch_cnt != GCNT_MAX)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_c3lib_sync_filter_multi.sv
module tb_c3lib_sync_filter_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] din_a, din_b, din_c;
  logic       clr_a, clr_b, clr_c;

  logic [3:0] out_a, rise_a, fall_a, busy_a;
  logic [3:0] out_b, rise_b, fall_b, busy_b;
  logic [3:0] out_c, rise_c, fall_c, busy_c;
  logic [7:0] gc_a, gc_b;
  logic [1:0] gc_c;

  // A: plain synchronizer with non-zero reset value
  c3lib_sync_filter_multi #(.WIDTH(4), .SYNC_STAGES(2), .RESET_VAL(4'b1010),
                            .FILTER_DEPTH(0), .GCNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(din_a), .glitch_clr(clr_a),
    .data_out(out_a), .rise_pls(rise_a), .fall_pls(fall_a),
    .filt_busy(busy_a), .glitch_cnt(gc_a));

  // B: 3-stage sync, depth-4 filter
  c3lib_sync_filter_multi #(.WIDTH(4), .SYNC_STAGES(3), .RESET_VAL(4'b0000),
                            .FILTER_DEPTH(4), .GCNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(din_b), .glitch_clr(clr_b),
    .data_out(out_b), .rise_pls(rise_b), .fall_pls(fall_b),
    .filt_busy(busy_b), .glitch_cnt(gc_b));

  // C: 2-stage sync, depth-4 filter, narrow glitch counter
  c3lib_sync_filter_multi #(.WIDTH(4), .SYNC_STAGES(2), .RESET_VAL(4'b0000),
                            .FILTER_DEPTH(4), .GCNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .data_in(din_c), .glitch_clr(clr_c),
    .data_out(out_c), .rise_pls(rise_c), .fall_pls(fall_c),
    .filt_busy(busy_c), .glitch_cnt(gc_c));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Keeps the input history per edge since reset release and
  // derives outputs from it: the synchronized value is the input seen
  // SYNC_STAGES-1 edges earlier, and an output bit flips once the synchronized
  // value has disagreed with it for N consecutive cycles.
  // ---------------------------------------------------------------------------
  int         m_ss   [3] = '{2, 3, 2};
  int         m_n    [3] = '{0, 4, 4};
  logic [3:0] m_rv   [3] = '{4'b1010, 4'b0000, 4'b0000};
  int         m_gmax [3] = '{255, 255, 3};

  logic [3:0] in_h  [3][4096];
  logic [3:0] out_h [3][4096];
  int         ec [3] = '{0, 0, 0};
  int         mg [3] = '{0, 0, 0};

  // synchronized value held after edge k
  function automatic logic [3:0] s_at(input int d, input int k);
    int m;
    m = k - m_ss[d] + 1;
    if (m < 1) return m_rv[d];
    return in_h[d][m % 4096];
  endfunction

  function automatic logic [3:0] o_at(input int d, input int k);
    if (k < 1) return m_rv[d];
    return out_h[d][k % 4096];
  endfunction

  task automatic model_edge(input int d, input logic [3:0] din, input logic clr);
    int k;
    logic [3:0] o, prev, sv, sv1, sv2;
    logic inc, all_diff;
    ec[d]++;
    k = ec[d];
    in_h[d][k % 4096] = din;
    prev = o_at(d, k - 1);
    inc  = 1'b0;
    if (m_n[d] == 0) begin
      o = s_at(d, k);
    end else begin
      o   = prev;
      sv1 = s_at(d, k - 1);
      sv2 = s_at(d, k - 2);
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= m_n[d]; j++) begin
          sv = s_at(d, k - j);
          if (sv[b] == prev[b]) all_diff = 1'b0;
        end
        if (all_diff) o[b] = ~prev[b];
        // disagreement in the previous cycle that has now fallen back
        if (sv1[b] == prev[b] && sv2[b] != prev[b]) inc = 1'b1;
      end
    end
    out_h[d][k % 4096] = o;
    if (clr) mg[d] = inc ? 1 : 0;
    else if (inc && mg[d] < m_gmax[d]) mg[d]++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (rst_n !== 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        ec[d] = 0;
        mg[d] = 0;
      end
    end else begin
      model_edge(0, din_a, clr_a);
      model_edge(1, din_b, clr_b);
      model_edge(2, din_c, clr_c);
    end
  end

  task automatic cmp_dut(input int d, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] bz, input logic [31:0] g);
    int k;
    logic [3:0] eo, ep, es, eb;
    k  = ec[d];
    eo = o_at(d, k);
    ep = o_at(d, k - 1);
    es = s_at(d, k - 1);
    eb = (m_n[d] == 0) ? 4'b0000 : (es ^ eo);
    check($sformatf("d%0d_data_out@%0d", d, k), o, eo);
    check($sformatf("d%0d_rise@%0d", d, k), r, eo & ~ep);
    check($sformatf("d%0d_fall@%0d", d, k), f, ~eo & ep);
    check($sformatf("d%0d_busy@%0d", d, k), bz, eb);
    check($sformatf("d%0d_gcnt@%0d", d, k), g, mg[d]);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      cmp_dut(0, out_a, rise_a, fall_a, busy_a, 32'(gc_a));
      cmp_dut(1, out_b, rise_b, fall_b, busy_b, 32'(gc_b));
      cmp_dut(2, out_c, rise_c, fall_c, busy_c, 32'(gc_c));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  int exp_seq [5] = '{1, 2, 3, 3, 3};
  int nb, lat, pls_seen;
  logic found;
  logic [3:0] rb;

  initial begin
    rst_n = 1'b0;
    din_a = 4'b1010; din_b = 4'b0000; din_c = 4'b0000;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    repeat (3) step();
    check("rst_a_out", out_a, 4'b1010);
    check("rst_a_pls", {rise_a, fall_a}, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_c_gcnt", gc_c, 0);
    rst_n = 1'b1;
    repeat (4) step();
    check("t1_no_pls_release", {rise_a, fall_a}, 0);
    check("t1_out_after_release", out_a, 4'b1010);

    // T1: two-edge latency, pulses for one cycle
    din_a = 4'b0101;
    step();
    check("t1_out_edge1", out_a, 4'b1010);
    step();
    check("t1_out_edge2", out_a, 4'b0101);
    check("t1_rise", rise_a, 4'b0101);
    check("t1_fall", fall_a, 4'b1010);
    step();
    check("t1_rise_gone", rise_a, 0);
    check("t1_fall_gone", fall_a, 0);

    // T2: 3 sync stages + depth 4 -> 7 edges, busy for 3 cycles
    din_b = 4'b0001;
    nb = 0; lat = 0; found = 1'b0; rb = 4'b0000;
    for (int i = 1; i <= 20 && !found; i++) begin
      step();
      if (busy_b[0]) nb++;
      if (out_b[0]) begin
        found = 1'b1;
        lat   = i;
        rb    = rise_b;
      end
    end
    check("t2_latency", lat, 7);
    check("t2_busy_cycles", nb, 3);
    check("t2_rise", rb, 4'b0001);
    step();
    check("t2_rise_single", rise_b, 0);

    // T3: 3-cycle pulses are rejected; simultaneous bits count once
    din_b = 4'b0011;
    repeat (3) step();
    din_b = 4'b0001;
    repeat (10) step();
    check("t3_out_kept", out_b, 4'b0001);
    check("t3_gcnt1", gc_b, 1);
    din_b = 4'b1101;
    repeat (3) step();
    din_b = 4'b0001;
    repeat (10) step();
    check("t3_out_kept2", out_b, 4'b0001);
    check("t3_gcnt2", gc_b, 2);

    // T4: 2-bit glitch counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      din_c = 4'b0001;
      repeat (2) step();
      din_c = 4'b0000;
      repeat (6) step();
      check($sformatf("t4_gcnt_%0d", i), gc_c, exp_seq[i]);
    end
    // clear in the same cycle as a reject: reject is kept
    din_c = 4'b0001;
    repeat (2) step();
    din_c = 4'b0000;
    repeat (2) step();
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    check("t4_clr_with_reject", gc_c, 1);
    check("t4_out_unchanged", out_c, 0);
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    check("t4_clr_alone", gc_c, 0);

    // T5: async reset while a change is pending
    din_c = 4'b0010;
    repeat (2) step();
    din_c = 4'b0000;
    repeat (6) step();
    check("t5_gcnt_pre", gc_c, 1);
    din_c = 4'b0001;
    repeat (4) step();
    check("t5_busy_pre", busy_c, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_c", out_c, 0);
    check("t5_rst_busy_c", busy_c, 0);
    check("t5_rst_gcnt_c", gc_c, 0);
    check("t5_rst_out_a", out_a, 4'b1010);
    check("t5_rst_gcnt_b", gc_b, 0);
    din_a = 4'b1010; din_b = 4'b0000; din_c = 4'b0000;
    repeat (2) step();
    rst_n = 1'b1;
    pls_seen = 0;
    repeat (8) begin
      step();
      if (|{rise_a, fall_a, rise_b, fall_b, rise_c, fall_c}) pls_seen++;
    end
    check("t5_no_pls_after_release", pls_seen, 0);
    check("t5_out_c_reset_val", out_c, 0);
    check("t5_out_a_reset_val", out_a, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
